// File: rtl/apb_timer_slave.sv
// APB2 slave: 32-bit down-counting timer with sticky EXPIRED flag and level Irq; PRdata registered at read setup.
// Optional prescaler: define TIMER_PRESCALER_EN to build the PRESCALE register and prescale counter.
module apb_timer_slave #(
  parameter int unsigned PRESC_W  = 16,
  parameter logic [31:0] LOAD_RST = 32'd0
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] PWdata,
  output logic [31:0] PRdata,
  output logic        Irq
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_LOAD   = 3'd1;
  localparam logic [2:0] A_VALUE  = 3'd2;
  localparam logic [2:0] A_PRESC  = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] value_q, value_d;
  logic [31:0] prdata_q, prdata_d;
  logic        expired_q, expired_d;
  logic [31:0] presc_rd;
  logic        tick;
  logic        wr_en, rd_setup;
  logic [2:0]  reg_sel;
  logic        unused_addr;

  assign reg_sel     = Paddr[4:2];
  assign wr_en       = Psel & Penable & Pwrite;
  assign rd_setup    = Psel & ~Penable & ~Pwrite;
  assign unused_addr = ^{Paddr[31:5], Paddr[1:0]};

`ifdef TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    presc_d = presc_q;
    if (wr_en && reg_sel == A_PRESC) presc_d = PWdata[PRESC_W-1:0];
    tick   = ctrl_q[0] && (pcnt_q == presc_q);
    // Count is forced to 0 while disabled so a restart always gets a full prescale period.
    pcnt_d = '0;
    if (ctrl_q[0] && !tick) pcnt_d = pcnt_q + 1'b1;
    presc_rd = '0;
    presc_rd[PRESC_W-1:0] = presc_q;
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick     = ctrl_q[0];
  assign presc_rd = '0;
`endif

  // Later assignments win: expiry beats W1C, register writes beat the tick update.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    value_d   = value_q;
    expired_d = expired_q;
    if (wr_en && reg_sel == A_STATUS && PWdata[0]) expired_d = 1'b0;
    if (tick) begin
      if (value_q != 32'd0) begin
        value_d = value_q - 32'd1;
      end else begin
        expired_d = 1'b1;
        if (ctrl_q[1]) value_d = load_q;
        else           ctrl_d[0] = 1'b0;
      end
    end
    if (wr_en && reg_sel == A_CTRL) ctrl_d = PWdata[2:0];
    if (wr_en && reg_sel == A_LOAD) begin
      load_d  = PWdata;
      value_d = PWdata;
    end
  end

  always_comb begin
    prdata_d = prdata_q;
    if (rd_setup) begin
      case (reg_sel)
        A_CTRL:   prdata_d = {29'd0, ctrl_q};
        A_LOAD:   prdata_d = load_q;
        A_VALUE:  prdata_d = value_q;
        A_PRESC:  prdata_d = presc_rd;
        A_STATUS: prdata_d = {31'd0, expired_q};
        default:  prdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      ctrl_q    <= 3'd0;
      load_q    <= LOAD_RST;
      value_q   <= 32'd0;
      expired_q <= 1'b0;
      prdata_q  <= 32'd0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      expired_q <= expired_d;
      prdata_q  <= prdata_d;
    end
  end

  assign PRdata = prdata_q;
  assign Irq    = expired_q & ctrl_q[2];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: register-map vector table plus timed sequences for one-shot,
// auto-reload, collisions, prescale and asynchronous reset; honours TIMER_PRESCALER_EN.
module tb_apb_timer_slave;
  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        Psel, Penable, Pwrite;
  logic [31:0] Paddr, PWdata, PRdata;
  logic        Irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
    string       name;
  } vec_t;

`ifdef TIMER_PRESCALER_EN
  localparam logic [31:0] PRESC_FF = 32'h0000_FFFF;
  localparam logic [31:0] PRESC_3  = 32'd3;
`else
  localparam logic [31:0] PRESC_FF = 32'd0;
  localparam logic [31:0] PRESC_3  = 32'd0;
`endif

  apb_timer_slave dut (
    .Hclk    (Hclk),
    .Hreset  (Hreset),
    .Psel    (Psel),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .PWdata  (PWdata),
    .PRdata  (PRdata),
    .Irq     (Irq)
  );

  always #5 Hclk = ~Hclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
  endtask

  task automatic step();
    @(posedge Hclk); #1;
  endtask

  // All bus tasks are entered 1ns after a rising edge and return 1ns after one.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = a; PWdata = d;
    step();
    Penable = 1'b1;
    step();
    idle();
  endtask

  task automatic apb_read(input logic [31:0] a, input logic [31:0] e, input string name);
    logic [31:0] x;
    exp_q.push_back(e);
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = a;
    step();
    Penable = 1'b1;
    x = exp_q.pop_front();
    check({name, " setup"}, PRdata, x);
    step();
    idle();
    check({name, " access"}, PRdata, x);
  endtask

  // Holds the read-setup phase so PRdata resamples the register on every edge.
  task automatic monitor(input logic [31:0] a, input int n, input string name);
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = a;
    for (int i = 0; i < n; i++) begin
      step();
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s[%0d]: scoreboard empty", name, i);
      end else begin
        check($sformatf("%s[%0d]", name, i), PRdata, exp_q.pop_front());
      end
    end
    idle();
  endtask

  initial begin
    vec_t tbl[$];
    idle();
    Paddr = 32'd0; PWdata = 32'd0; Hreset = 1'b1;
    repeat (2) @(posedge Hclk);
    #1 Hreset = 1'b0;
    step();
    check("reset PRdata", PRdata, 32'd0);
    check("reset Irq", {31'd0, Irq}, 32'd0);

    // Register map and address decode
    tbl.push_back('{1'b0, 32'h00, 32'h0,         "rst CTRL"});
    tbl.push_back('{1'b0, 32'h04, 32'h0,         "rst LOAD"});
    tbl.push_back('{1'b0, 32'h08, 32'h0,         "rst VALUE"});
    tbl.push_back('{1'b0, 32'h0C, 32'h0,         "rst PRESCALE"});
    tbl.push_back('{1'b0, 32'h10, 32'h0,         "rst STATUS"});
    tbl.push_back('{1'b0, 32'h1C, 32'h0,         "rst 0x1C"});
    tbl.push_back('{1'b1, 32'h04, 32'hA5A50003,  "wr LOAD"});
    tbl.push_back('{1'b0, 32'h04, 32'hA5A50003,  "LOAD rb"});
    tbl.push_back('{1'b0, 32'h08, 32'hA5A50003,  "VALUE copy"});
    tbl.push_back('{1'b1, 32'h08, 32'hDEADBEEF,  "wr VALUE"});
    tbl.push_back('{1'b0, 32'h08, 32'hA5A50003,  "VALUE ro"});
    tbl.push_back('{1'b1, 32'h18, 32'hDEADBEEF,  "wr 0x18"});
    tbl.push_back('{1'b0, 32'h18, 32'h0,         "0x18 rd"});
    tbl.push_back('{1'b0, 32'h04, 32'hA5A50003,  "LOAD after 0x18"});
    tbl.push_back('{1'b1, 32'h00, 32'hFFFFFFF2,  "wr CTRL"});
    tbl.push_back('{1'b0, 32'h00, 32'h2,         "CTRL mask"});
    tbl.push_back('{1'b1, 32'h0C, 32'hFFFFFFFF,  "wr PRESCALE"});
    tbl.push_back('{1'b0, 32'h0C, PRESC_FF,      "PRESCALE mask"});
    tbl.push_back('{1'b1, 32'h0C, 32'h0,         "clr PRESCALE"});
    tbl.push_back('{1'b0, 32'h0C, 32'h0,         "PRESCALE zero"});
    tbl.push_back('{1'b1, 32'h107, 32'h5,        "wr LOAD alias"});
    tbl.push_back('{1'b0, 32'h08, 32'h5,         "VALUE alias"});
    tbl.push_back('{1'b0, 32'h04, 32'h5,         "LOAD alias"});
    tbl.push_back('{1'b1, 32'h00, 32'h0,         "clr CTRL"});
    foreach (tbl[i]) begin
      if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
      else           apb_read(tbl[i].addr, tbl[i].data, tbl[i].name);
    end
    check("PRdata hold after write", PRdata, 32'h5);

    // One-shot: VALUE 3,2,1,0 then expiry clears EN
    apb_write(32'h04, 32'd3);
    apb_write(32'h00, 32'h5);
    exp_q.push_back(32'd3); exp_q.push_back(32'd2); exp_q.push_back(32'd1);
    monitor(32'h08, 3, "oneshot VALUE");
    check("oneshot Irq before expiry", {31'd0, Irq}, 32'd0);
    exp_q.push_back(32'd0);
    monitor(32'h08, 1, "oneshot VALUE end");
    check("oneshot Irq", {31'd0, Irq}, 32'd1);
    apb_read(32'h00, 32'h4, "oneshot CTRL");
    apb_read(32'h10, 32'h1, "oneshot STATUS");

    // Asynchronous reset in the middle of an access and a count
    apb_write(32'h04, 32'd100);
    apb_write(32'h00, 32'h5);
    step(); step();
    Psel = 1'b1; Penable = 1'b1; Pwrite = 1'b0; Paddr = 32'h08;
    check("pre-reset Irq", {31'd0, Irq}, 32'd1);
    Hreset = 1'b1;
    #2;
    check("async reset PRdata", PRdata, 32'd0);
    check("async reset Irq", {31'd0, Irq}, 32'd0);
    step();
    Hreset = 1'b0;
    idle();
    step();
    apb_read(32'h00, 32'h0, "post-reset CTRL");
    apb_read(32'h04, 32'h0, "post-reset LOAD");
    apb_read(32'h08, 32'h0, "post-reset VALUE");
    apb_read(32'h10, 32'h0, "post-reset STATUS");

    // Auto-reload with period 2, W1C on and off the expiry edge
    apb_write(32'h04, 32'd1);
    apb_write(32'h00, 32'h7);
    step();
    check("reload Irq low", {31'd0, Irq}, 32'd0);
    step();
    check("reload Irq first expiry", {31'd0, Irq}, 32'd1);
    apb_write(32'h10, 32'h1);
    check("W1C on expiry keeps Irq", {31'd0, Irq}, 32'd1);
    step();
    apb_write(32'h10, 32'h1);
    check("W1C clears Irq", {31'd0, Irq}, 32'd0);
    step();
    check("Irq reasserts", {31'd0, Irq}, 32'd1);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    monitor(32'h08, 4, "reload VALUE");

    // LOAD write on a tick wins, then pause by clearing EN
    apb_write(32'h04, 32'h10);
    apb_read(32'h08, 32'h10, "LOAD on tick");
    apb_write(32'h00, 32'h0);
    apb_read(32'h08, 32'hC, "paused VALUE");
    apb_read(32'h08, 32'hC, "paused VALUE again");

    // Prescale
    apb_write(32'h0C, 32'd3);
    apb_read(32'h0C, PRESC_3, "PRESCALE 3 rb");
    apb_write(32'h04, 32'd2);
    apb_write(32'h00, 32'h1);
`ifdef TIMER_PRESCALER_EN
    for (int v = 2; v >= 0; v--)
      for (int k = 0; k < 4; k++) exp_q.push_back(32'(v));
    monitor(32'h08, 12, "prescale VALUE");
`else
    exp_q.push_back(32'd2); exp_q.push_back(32'd1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    monitor(32'h08, 4, "no-prescale VALUE");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
